// File: rtl/ghost_hit_ctrl_pkg.sv
// ghost_hit_ctrl_pkg
// Shared game constants and small helpers for the ghost/Yoshi collision logic.
//   T_W      : sprite edge length in pixels (Yoshi and ghost are both square)
//   MAX_X/Y  : visible screen size; sets the coordinate width
//   TIME_MAX : ghost tick period; speed_offset must always stay below it
package ghost_hit_ctrl_pkg;

  localparam int T_W      = 16;
  localparam int MAX_X    = 640;
  localparam int MAX_Y    = 480;
  localparam int TIME_MAX = 4000000;

  localparam int COORD_W  = $clog2((MAX_X > MAX_Y) ? MAX_X : MAX_Y);
  localparam int SPEED_W  = 26;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SPEED_W-1:0] speed_t;

  // Saturating speed increment; the extra bit keeps the sum from wrapping
  // before it is compared against the cap.
  function automatic speed_t speed_step(input speed_t cur, input int step, input int cap);
    logic [SPEED_W:0] sum;
    sum = {1'b0, cur} + (SPEED_W+1)'(step);
    if (sum > (SPEED_W+1)'(cap))
      return SPEED_W'(cap);
    return sum[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/ghost_hit_ctrl_if.sv
// ghost_hit_ctrl_if
// Bundle between the game world (positions, restart button) and the hit
// controller (lives, speed feedback, renderer strobes).
//   y_x, y_y       : Yoshi top-left position
//   g_c_x, g_c_y   : ghost top-left position
//   start          : level-sensitive restart request
//   speed_offset   : ghost tick-period reduction
//   lives          : remaining lives
//   hit            : one-cycle pulse per accepted collision
//   invuln         : high while hits are ignored
//   blink          : sprite-hide strobe for the Yoshi renderer
//   game_over      : high once all lives are gone
interface ghost_hit_ctrl_if;
  import ghost_hit_ctrl_pkg::*;

  coord_t     y_x;
  coord_t     y_y;
  coord_t     g_c_x;
  coord_t     g_c_y;
  logic       start;
  speed_t     speed_offset;
  logic [1:0] lives;
  logic       hit;
  logic       invuln;
  logic       blink;
  logic       game_over;

  // slave: the hit controller itself
  modport slave (
    input  y_x, y_y, g_c_x, g_c_y, start,
    output speed_offset, lives, hit, invuln, blink, game_over
  );

  // master: whatever drives positions and consumes the game status
  modport master (
    output y_x, y_y, g_c_x, g_c_y, start,
    input  speed_offset, lives, hit, invuln, blink, game_over
  );

endinterface

// File: rtl/ghost_hit_ctrl_box_overlap.sv
// box_overlap
// Purely combinational axis-aligned overlap test of two T_W x T_W boxes.
//   ax, ay : top-left of box A
//   bx, by : top-left of box B
//   overlap: high when the boxes intersect on both axes
module box_overlap
  import ghost_hit_ctrl_pkg::*;
#(
  parameter int T_W = ghost_hit_ctrl_pkg::T_W
) (
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t bx,
  input  coord_t by,
  output logic   overlap
);

  coord_t dx;
  coord_t dy;

  // Larger-minus-smaller keeps the distance unsigned with no wraparound.
  always_comb begin
    dx      = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy      = (ay >= by) ? (ay - by) : (by - ay);
    overlap = (dx < COORD_W'(T_W)) && (dy < COORD_W'(T_W));
  end

endmodule

// File: rtl/ghost_hit_ctrl.sv
// ghost_hit_ctrl
// Collision / lives / difficulty controller for the Yoshi vs. ghost game.
//   clk   : system clock, everything on the rising edge
//   reset : synchronous active-high reset
//   bus   : ghost_hit_ctrl_if.slave (positions and start in, status out)
// A registered overlap drives a four-state FSM (PLAY, HIT, INVULN, OVER).
// While playing, a level counter periodically raises speed_offset; each hit
// halves it and removes a life.
module ghost_hit_ctrl
  import ghost_hit_ctrl_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int INV_CYCLES   = 25000000,
  parameter int LEVEL_CYCLES = 250000000,
  parameter int SPEED_STEP   = 200000,
  parameter int SPEED_MAX    = 3000000,
  parameter int T_W          = ghost_hit_ctrl_pkg::T_W
) (
  input logic          clk,
  input logic          reset,
  ghost_hit_ctrl_if.slave bus
);

  localparam logic [1:0] PLAY   = 2'd0;
  localparam logic [1:0] HIT    = 2'd1;
  localparam logic [1:0] INVULN = 2'd2;
  localparam logic [1:0] OVER   = 2'd3;

  // The cap is clamped below the ghost tick period so the ghost never stalls.
  localparam int SPEED_CAP = (SPEED_MAX < TIME_MAX) ? SPEED_MAX : TIME_MAX - 1;

  localparam logic [24:0] INV_LAST   = 25'(INV_CYCLES - 1);
  localparam logic [27:0] LEVEL_LAST = 28'(LEVEL_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  lives_q;
  speed_t      speed_q;
  logic [24:0] inv_cnt;
  logic [27:0] level_cnt;
  logic        overlap;
  logic        overlap_q;

  box_overlap #(.T_W(T_W)) u_box_overlap (
    .ax      (bus.y_x),
    .ay      (bus.y_y),
    .bx      (bus.g_c_x),
    .by      (bus.g_c_y),
    .overlap (overlap)
  );

  // Main state register. A hit in PLAY always wins over a level step in the
  // same cycle: the step is dropped and the level counter simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      lives_q   <= 2'(LIVES_INIT);
      speed_q   <= '0;
      inv_cnt   <= '0;
      level_cnt <= '0;
      overlap_q <= 1'b0;
    end else begin
      overlap_q <= overlap;
      case (state)
        PLAY: begin
          if (overlap_q) begin
            if (lives_q == 2'd1) begin
              state   <= OVER;
              lives_q <= 2'd0;
            end else begin
              state   <= HIT;
              lives_q <= lives_q - 2'd1;
              speed_q <= speed_q >> 1;
            end
          end else if (level_cnt == LEVEL_LAST) begin
            level_cnt <= '0;
            speed_q   <= speed_step(speed_q, SPEED_STEP, SPEED_CAP);
          end else begin
            level_cnt <= level_cnt + 28'd1;
          end
        end
        HIT: begin
          state   <= INVULN;
          inv_cnt <= '0;
        end
        INVULN: begin
          if (inv_cnt == INV_LAST) begin
            state   <= PLAY;
            inv_cnt <= '0;
          end else begin
            inv_cnt <= inv_cnt + 25'd1;
          end
        end
        OVER: begin
          if (bus.start) begin
            state     <= PLAY;
            lives_q   <= 2'(LIVES_INIT);
            speed_q   <= '0;
            level_cnt <= '0;
            inv_cnt   <= '0;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  // Outputs decode only registered state, so there is no input-to-output path.
  // The final hit never enters HIT, so its pulse is decoded from the PLAY cycle
  // that commits the move to OVER.
  always_comb begin
    bus.hit          = (state == HIT) ||
                       ((state == PLAY) && overlap_q && (lives_q == 2'd1));
    bus.invuln       = (state == HIT) || (state == INVULN);
    bus.blink        = bus.invuln && inv_cnt[22];
    bus.game_over    = (state == OVER);
    bus.lives        = lives_q;
    bus.speed_offset = speed_q;
  end

endmodule
